// File: rtl/spi_pkg.sv
// Shared SafetyBoard SPI definitions: command codes, frame constants and the master FSM states.
package spi_pkg;

  localparam logic [7:0] CMD_VERSION = 8'h01;
  localparam logic [7:0] CMD_WRITE   = 8'h10;
  localparam logic [7:0] CMD_READ    = 8'h20;

  localparam int         SPI_FRAME_BITS = 32;
  localparam logic [7:0] SPI_RSP_HDR    = 8'hA5;
  localparam logic [7:0] SPI_RSP_PAD    = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } spi_mst_state_e;

  function automatic logic [7:0] spi_xor_chk(input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] c);
    return a ^ b ^ c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for signals crossing into the clk domain.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: sends {cmd, addr, data, checksum}, captures the 4 returned bytes and
// reports read data plus header/checksum integrity on a single-cycle response strobe.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_GAP   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_cmd,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_hdr_ok,
  output logic       rsp_chk_ok,
  output logic       busy,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  input  logic       miso
);

  localparam int CNT_MAX = (CLK_DIV > CS_SETUP) ? ((CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP)
                                                : ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  spi_mst_state_e state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       bit_cnt;
  logic [31:0]      tx_shift;
  logic [31:0]      rx_shift;
  logic [7:0]       cmd_q;
  logic [7:0]       addr_q;
  logic             miso_s;

  sync_2ff #(.W(1)) u_miso_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (miso),
    .q    (miso_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      tx_shift   <= '0;
      rx_shift   <= '0;
      cmd_q      <= '0;
      addr_q     <= '0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_hdr_ok <= 1'b0;
      rsp_chk_ok <= 1'b0;
      sclk       <= 1'b0;
      cs_n       <= 1'b1;
      mosi       <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            tx_shift  <= {req_cmd, req_addr, req_wdata, spi_xor_chk(req_cmd, req_addr, req_wdata)};
            cmd_q     <= req_cmd;
            addr_q    <= req_addr;
            cs_n      <= 1'b0;
            mosi      <= req_cmd[7];
            req_ready <= 1'b0;
            busy      <= 1'b1;
            cnt       <= '0;
            bit_cnt   <= '0;
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == CNT_W'(CS_SETUP - 1)) begin
            cnt   <= '0;
            state <= ST_SHIFT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_SHIFT: begin
          // Each bit: CLK_DIV cycles low, then CLK_DIV cycles high; sample on rise, advance on fall.
          if (cnt == CNT_W'(CLK_DIV - 1)) begin
            cnt <= '0;
            if (!sclk) begin
              sclk     <= 1'b1;
              rx_shift <= {rx_shift[30:0], miso_s};
            end else begin
              sclk     <= 1'b0;
              tx_shift <= {tx_shift[30:0], 1'b0};
              mosi     <= tx_shift[30];
              bit_cnt  <= bit_cnt + 5'd1;
              if (bit_cnt == 5'(SPI_FRAME_BITS - 1)) state <= ST_HOLD;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (cnt == CNT_W'(CS_SETUP - 1)) begin
            cnt        <= '0;
            cs_n       <= 1'b1;
            mosi       <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_rdata  <= rx_shift[15:8];
            rsp_hdr_ok <= (rx_shift[31:24] == SPI_RSP_HDR) && (rx_shift[23:16] == SPI_RSP_PAD);
            rsp_chk_ok <= rx_shift[7:0] == spi_xor_chk(cmd_q, addr_q, rx_shift[15:8]);
            state      <= ST_GAP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (cnt == CNT_W'(CS_GAP - 1)) begin
            cnt       <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: three instances (default timing, CLK_DIV=3/CS_SETUP=1, CLK_DIV=8/CS_SETUP=1)
// each talking to a behavioural mode-0 slave that returns a programmed 32-bit word.
module tb_spi_master;
  import spi_pkg::*;

  localparam int NCH = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       req_valid[NCH], req_ready[NCH], rsp_valid[NCH], rsp_hdr_ok[NCH], rsp_chk_ok[NCH];
  logic       busy[NCH], sclk[NCH], cs_n[NCH], mosi[NCH], miso[NCH];
  logic [7:0] req_cmd[NCH], req_addr[NCH], req_wdata[NCH], rsp_rdata[NCH];

  spi_master #(.CLK_DIV(4), .CS_SETUP(2), .CS_GAP(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_cmd(req_cmd[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_hdr_ok(rsp_hdr_ok[0]),
    .rsp_chk_ok(rsp_chk_ok[0]), .busy(busy[0]), .sclk(sclk[0]), .cs_n(cs_n[0]),
    .mosi(mosi[0]), .miso(miso[0]));

  spi_master #(.CLK_DIV(3), .CS_SETUP(1), .CS_GAP(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_cmd(req_cmd[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_hdr_ok(rsp_hdr_ok[1]),
    .rsp_chk_ok(rsp_chk_ok[1]), .busy(busy[1]), .sclk(sclk[1]), .cs_n(cs_n[1]),
    .mosi(mosi[1]), .miso(miso[1]));

  spi_master #(.CLK_DIV(8), .CS_SETUP(1), .CS_GAP(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_cmd(req_cmd[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_hdr_ok(rsp_hdr_ok[2]),
    .rsp_chk_ok(rsp_chk_ok[2]), .busy(busy[2]), .sclk(sclk[2]), .cs_n(cs_n[2]),
    .mosi(mosi[2]), .miso(miso[2]));

  function automatic int div_of(input int c);
    return (c == 1) ? 3 : ((c == 2) ? 8 : 4);
  endfunction

  function automatic int cs_of(input int c);
    return (c == 0) ? 2 : 1;
  endfunction

  // Slave model and line monitor, all observed on the falling clk edge
  int          t = 0;
  int          rise_cnt[NCH], frames[NCH], rsp_cnt[NCH], per_err[NCH], inv_err[NCH];
  int          cs_fall_t[NCH], first_rise_t[NCH], last_rise_t[NCH], last_fall_t[NCH];
  int          cs_rise_t[NCH], last_gap[NCH];
  logic [31:0] mosi_cap[NCH], slv_word[NCH], slv_sh[NCH];
  logic        prev_sclk[NCH], prev_cs[NCH];

  always @(negedge clk) begin
    t++;
    for (int c = 0; c < NCH; c++) begin
      if (!rst_n) begin
        prev_sclk[c] = 1'b0;
        prev_cs[c]   = 1'b1;
        miso[c]      = 1'b0;
      end else begin
        if (req_ready[c] == busy[c]) inv_err[c]++;
        if (cs_n[c] && mosi[c]) inv_err[c]++;
        if (prev_cs[c] && !cs_n[c]) begin
          frames[c]++;
          last_gap[c]  = t - cs_rise_t[c];
          cs_fall_t[c] = t;
          rise_cnt[c]  = 0;
          mosi_cap[c]  = '0;
          slv_sh[c]    = slv_word[c];
          miso[c]      = slv_word[c][31];
        end
        if (!prev_cs[c] && cs_n[c]) begin
          cs_rise_t[c] = t;
          miso[c]      = 1'b0;
        end
        if (!cs_n[c] && !prev_sclk[c] && sclk[c]) begin
          if (rise_cnt[c] == 0) first_rise_t[c] = t;
          else if (t - last_rise_t[c] != 2 * div_of(c)) per_err[c]++;
          last_rise_t[c] = t;
          rise_cnt[c]++;
          mosi_cap[c] = {mosi_cap[c][30:0], mosi[c]};
        end
        if (!cs_n[c] && prev_sclk[c] && !sclk[c]) begin
          last_fall_t[c] = t;
          slv_sh[c]      = slv_sh[c] << 1;
          miso[c]        = slv_sh[c][31];
        end
        if (rsp_valid[c]) rsp_cnt[c]++;
        prev_sclk[c] = sclk[c];
        prev_cs[c]   = cs_n[c];
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  addr;
    logic [7:0]  wd;
    logic [31:0] ret;
    logic [31:0] exp_mosi;
    logic [7:0]  exp_rdata;
    logic        exp_hdr;
    logic        exp_chk;
  } vec_t;

  vec_t vt[6];

  task automatic start_req(input int c, input logic [7:0] cmd, input logic [7:0] addr,
                           input logic [7:0] wd);
    int k = 0;
    while (!req_ready[c] && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("ready_wait", 32'(k < 2000), 32'd1);
    req_cmd[c]   = cmd;
    req_addr[c]  = addr;
    req_wdata[c] = wd;
    req_valid[c] = 1'b1;
  endtask

  // mode 1: drop req_valid after accept; mode 2: keep valid and present the next request
  task automatic wait_rsp(input int c, input int mode, input logic [7:0] ncmd,
                          input logic [7:0] naddr, input logic [7:0] nwd, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1 && mode == 1) req_valid[c] = 1'b0;
      if (lat == 1 && mode == 2) begin
        check("b2b_ready_low", 32'(req_ready[c]), 32'd0);
        req_cmd[c]   = ncmd;
        req_addr[c]  = naddr;
        req_wdata[c] = nwd;
      end
    end while (!rsp_valid[c] && lat < 3000);
    check("rsp_wait", 32'(lat < 3000), 32'd1);
  endtask

  task automatic check_frame(input int c, input vec_t v, input int exp_lat, input int lat);
    check("latency", lat, exp_lat);
    check("rdata", rsp_rdata[c], v.exp_rdata);
    check("hdr_ok", rsp_hdr_ok[c], v.exp_hdr);
    check("chk_ok", rsp_chk_ok[c], v.exp_chk);
    @(negedge clk);
    check("rsp_pulse_width", rsp_valid[c], 1'b0);
    check("rdata_hold", rsp_rdata[c], v.exp_rdata);
    check("mosi_stream", mosi_cap[c], v.exp_mosi);
    check("sclk_rises", rise_cnt[c], 32);
    check("cs_to_first_rise", first_rise_t[c] - cs_fall_t[c], cs_of(c) + div_of(c));
    check("last_fall_to_cs", cs_rise_t[c] - last_fall_t[c], cs_of(c));
  endtask

  task automatic run_vec(input int c, input vec_t v, input int exp_lat);
    int lat;
    slv_word[c] = v.ret;
    start_req(c, v.cmd, v.addr, v.wd);
    wait_rsp(c, 1, 8'h00, 8'h00, 8'h00, lat);
    check_frame(c, v, exp_lat, lat);
  endtask

  initial begin
    int lat, f0, r0, k;

    vt[0] = '{8'h10, 8'h05, 8'h01, 32'hA5000015, 32'h10050114, 8'h00, 1'b1, 1'b1};
    vt[1] = '{CMD_VERSION, 8'h00, 8'h00, 32'hA5004243, 32'h01000001, 8'h42, 1'b1, 1'b1};
    vt[2] = '{CMD_VERSION, 8'h00, 8'h00, 32'hA5004242, 32'h01000001, 8'h42, 1'b1, 1'b0};
    vt[3] = '{CMD_VERSION, 8'h00, 8'h00, 32'h00004243, 32'h01000001, 8'h42, 1'b0, 1'b1};
    vt[4] = '{CMD_VERSION, 8'h00, 8'h00, 32'hA5014243, 32'h01000001, 8'h42, 1'b0, 1'b1};
    vt[5] = '{8'h20, 8'h7F, 8'hFF, 32'hA5005A05, 32'h207FFFA0, 8'h5A, 1'b1, 1'b1};

    for (int c = 0; c < NCH; c++) begin
      req_valid[c] = 1'b0; req_cmd[c] = '0; req_addr[c] = '0; req_wdata[c] = '0;
      miso[c] = 1'b0; slv_word[c] = '0; slv_sh[c] = '0; mosi_cap[c] = '0;
      prev_sclk[c] = 1'b0; prev_cs[c] = 1'b1;
      rise_cnt[c] = 0; frames[c] = 0; rsp_cnt[c] = 0; per_err[c] = 0; inv_err[c] = 0;
      cs_fall_t[c] = 0; first_rise_t[c] = 0; last_rise_t[c] = 0; last_fall_t[c] = 0;
      cs_rise_t[c] = -1000; last_gap[c] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", {cs_n[0], sclk[0], mosi[0], req_ready[0], busy[0], rsp_valid[0],
                         rsp_hdr_ok[0], rsp_chk_ok[0], rsp_rdata[0]}, 16'h9000);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_outs", {cs_n[0], sclk[0], mosi[0], req_ready[0], busy[0], rsp_valid[0]},
          6'b100100);

    for (int i = 0; i < 6; i++) run_vec(0, vt[i], 261);

    // Back-to-back: valid held high across two requests
    slv_word[0] = vt[5].ret;
    f0 = frames[0];
    start_req(0, vt[0].cmd, vt[0].addr, vt[0].wd);
    wait_rsp(0, 2, vt[5].cmd, vt[5].addr, vt[5].wd, lat);
    check("b2b_first_latency", lat, 261);
    @(negedge clk);
    check("b2b_first_mosi", mosi_cap[0], vt[0].exp_mosi);
    k = 0;
    while (!req_ready[0] && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("b2b_gap_wait", 32'(k < 100), 32'd1);
    wait_rsp(0, 1, 8'h00, 8'h00, 8'h00, lat);
    check_frame(0, vt[5], 261, lat);
    check("b2b_cs_gap", 32'(last_gap[0] >= 4), 32'd1);
    repeat (300) @(negedge clk);
    check("b2b_frame_count", frames[0] - f0, 2);

    // Reset in the middle of bit 13
    slv_word[0] = vt[1].ret;
    start_req(0, vt[1].cmd, vt[1].addr, vt[1].wd);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) req_valid[0] = 1'b0;
    end while (rise_cnt[0] < 13 && k < 3000);
    check("midreset_reach_bit13", 32'(k < 3000), 32'd1);
    r0 = rsp_cnt[0];
    f0 = frames[0];
    rst_n = 1'b0;
    #1;
    check("midreset_outs", {cs_n[0], sclk[0], mosi[0], busy[0], req_ready[0], rsp_valid[0]},
          6'b100010);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    check("midreset_no_rsp", rsp_cnt[0] - r0, 0);
    check("midreset_no_frame", frames[0] - f0, 0);
    run_vec(0, vt[5], 261);

    // Timing parameter sweep
    run_vec(1, vt[1], 195);
    run_vec(1, vt[2], 195);
    run_vec(2, vt[5], 515);

    for (int c = 0; c < NCH; c++) begin
      check("sclk_period", per_err[c], 0);
      check("ready_busy_mosi_invariants", inv_err[c], 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
